aoi_response_checker: RTL and testbench

//   Sequential response analyser for the four-input AOI gate: the receiving end of the stimulus sweep.

---
 rtl/aoi_pkg.sv | 30 +++
 rtl/aoi_delay_line.sv | 37 +++
 rtl/aoi_response_checker.sv | 140 ++++++++++++++
 tb/tb_aoi_response_checker.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aoi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aoi_pkg
//  Description : Shared types and the golden AOI function for the response
//                checker slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package aoi_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    localparam int c_STIM_W = 4;

    // Golden outputs {e,f,g} of the four-input AOI gate for stim {a,b,c,d}
    function automatic logic [2:0] aoi_expected(input logic [3:0] s);
        logic w_ab;
        logic w_cd;
        w_ab = s[3] & s[2];
        w_cd = s[1] & s[0];
        return {w_ab, w_cd, ~(w_ab | w_cd)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aoi_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : aoi_delay_line
//  Description : DEPTH-stage shift register with synchronous clear; carries
//                {valid, stim} alongside the gate under test.
//  Revision    : 1.0 - initial release
// ============================================================================
module aoi_delay_line #(
    parameter int W     = 5,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    logic [W-1:0] r_stage [DEPTH];

    // Shift one stage per clock; reset flushes every stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= in;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign out = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/aoi_response_checker.sv
`default_nettype none
// ============================================================================
//  Module      : aoi_response_checker
//  Description : Compares AOI gate outputs against golden values over a sweep
//                of NUM_VEC vectors; counts errors, latches the first failing
//                vector and reports pass/fail via a start/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module aoi_response_checker
    import aoi_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int NUM_VEC = 16,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stim_valid,
    input  logic [3:0]       stim,
    input  logic             dut_e,
    input  logic             dut_f,
    input  logic             dut_g,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_vld,
    output logic [3:0]       first_fail_vec
);

    localparam logic [7:0] c_LAST_IDX = 8'(NUM_VEC - 1);

    chk_state_t r_state;
    logic [7:0] r_vec_cnt;
    logic [3:0] r_inflight;

    logic       w_start_acc;
    logic       w_push;
    logic       w_last;
    logic [4:0] w_dl_in;
    logic [4:0] w_dl_out;
    logic       w_cmp_vld;
    logic [2:0] w_exp;
    logic [2:0] w_obs;
    logic       w_mismatch;

    assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_push      = (r_state == RUN) && stim_valid;
    assign w_last      = w_push && (r_vec_cnt == c_LAST_IDX);
    assign w_dl_in     = {w_push, stim & {4{w_push}}};

    aoi_delay_line #(
        .W     (5),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (w_dl_in),
        .out   (w_dl_out)
    );

    assign w_cmp_vld = w_dl_out[4];
    assign w_exp     = aoi_expected(w_dl_out[3:0]);
    assign w_obs     = {dut_e, dut_f, dut_g};
    // Case inequality so an X/Z response is treated as a failure in simulation
    assign w_mismatch = w_cmp_vld && (w_exp !== w_obs);

    // Number of valid entries currently inside the delay line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= 4'd0;
        end else begin
            r_inflight <= r_inflight + 4'(w_push) - 4'(w_cmp_vld);
        end
    end

    // Sweep controller with registered busy/done/pass
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_vec_cnt <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state   <= RUN;
                        r_vec_cnt <= 8'd0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_push) begin
                        r_vec_cnt <= r_vec_cnt + 8'd1;
                        if (w_last) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (r_inflight == 4'd0) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_count == '0);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Error counter and first-failure capture, cleared by an accepted start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count      <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= 4'h0;
        end else if (w_start_acc) begin
            err_count      <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= 4'h0;
        end else if (w_mismatch) begin
            if (err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
            if (!first_fail_vld) begin
                first_fail_vld <= 1'b1;
                first_fail_vec <= w_dl_out[3:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aoi_response_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aoi_response_checker
//  Description : Two checker instances (LATENCY=1/ERR_W=8 and LATENCY=4/
//                ERR_W=2) driven by a shared sweep stimulus and a faultable
//                AOI gate model, checked against a timestamp-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aoi_response_checker;

    localparam int NV = 16;

    typedef struct {
        int         due;
        logic [3:0] s;
        logic [2:0] obs;
    } pend_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stim_valid;
    logic [3:0] stim;
    int         fault;
    int         sweep_id;
    int         last_edge;
    int         cyc;
    logic       rst_seen;
    int         to_cnt;
    int         to_seen;
    int         n_pass;
    int         n_total;
    logic       prev_done0;
    logic       prev_done1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter; the value seen at an edge is that edge's index
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= !rst_n;
    end

    // Spec rule for the golden gate response
    function automatic logic [2:0] spec_exp(input logic [3:0] s);
        logic ab, cd;
        ab = s[3] & s[2];
        cd = s[1] & s[0];
        return {ab, cd, ~(ab | cd)};
    endfunction

    // Gate under test with selectable fault
    function automatic logic [2:0] gate_out(input logic [3:0] s, input int mode);
        logic [2:0] r;
        r = spec_exp(s);
        case (mode)
            1: r[0] = 1'b0;
            2: if (s == 4'hB) r[1] = ~r[1];
            3: r = ~r;
            default: ;
        endcase
        return r;
    endfunction

    function automatic int lit_err(input int s, input int k);
        case (s)
            0: return 0;
            1: return (k == 0) ? 9 : 3;
            2: return 1;
            3: return 0;
            4: return (k == 0) ? 16 : 3;
            6: return 0;
            default: return -1;
        endcase
    endfunction

    function automatic int lit_ffvec(input int s);
        case (s)
            1: return 0;
            2: return 11;
            4: return 0;
            default: return -1;
        endcase
    endfunction

    genvar k;
    generate
        for (k = 0; k < 2; k++) begin : g_cfg
            localparam int LAT  = (k == 0) ? 1 : 4;
            localparam int EW   = (k == 0) ? 8 : 2;
            localparam int EMAX = (1 << EW) - 1;

            logic          busy, done, pass, ffv;
            logic [EW-1:0] err_count;
            logic [3:0]    ffvec;
            logic [2:0]    gp [LAT];

            // Gate pipeline: response appears LAT cycles after the stim
            always @(posedge clk) begin
                gp[0] <= gate_out(stim, fault);
                for (int i = 1; i < LAT; i++) gp[i] <= gp[i-1];
            end

            aoi_response_checker #(
                .LATENCY (LAT),
                .NUM_VEC (NV),
                .ERR_W   (EW)
            ) u_dut (
                .clk            (clk),
                .rst_n          (rst_n),
                .start          (start),
                .stim_valid     (stim_valid),
                .stim           (stim),
                .dut_e          (gp[LAT-1][2]),
                .dut_f          (gp[LAT-1][1]),
                .dut_g          (gp[LAT-1][0]),
                .busy           (busy),
                .done           (done),
                .pass           (pass),
                .err_count      (err_count),
                .first_fail_vld (ffv),
                .first_fail_vec (ffvec)
            );

            // Reference model: accepted vectors are scheduled for comparison
            // LAT edges later; done lands LAT+1 edges after the last one.
            bit         m_busy, m_done, m_pass, m_ffv;
            int         m_err, m_nacc, m_last_t;
            logic [3:0] m_ffvec;
            pend_t      pq[$];

            always @(posedge clk) begin
                bit    b;
                pend_t pe;
                if (!rst_n) begin
                    m_busy = 0; m_done = 0; m_pass = 0; m_ffv = 0;
                    m_err = 0; m_nacc = 0; m_ffvec = 4'h0;
                    pq.delete();
                end else begin
                    b = m_busy;
                    while (pq.size() > 0 && pq[0].due == cyc) begin
                        pe = pq.pop_front();
                        if (spec_exp(pe.s) != pe.obs) begin
                            if (m_err < EMAX) m_err++;
                            if (!m_ffv) begin m_ffv = 1; m_ffvec = pe.s; end
                        end
                    end
                    if (b && m_nacc == NV && cyc == m_last_t + LAT + 1) begin
                        m_busy = 0; m_done = 1; m_pass = (m_err == 0);
                    end
                    if (start && !b) begin
                        m_busy = 1; m_done = 0; m_pass = 0; m_ffv = 0;
                        m_err = 0; m_nacc = 0; m_ffvec = 4'h0;
                    end else if (b && m_nacc < NV && stim_valid) begin
                        pq.push_back('{cyc + LAT, stim, gate_out(stim, fault)});
                        m_nacc++;
                        if (m_nacc == NV) m_last_t = cyc;
                    end
                end
            end
        end
    endgenerate

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic cmp_inst(input int kk, input int lat,
                            input logic busy, input logic done, input logic pass,
                            input logic [7:0] err, input logic ffv, input logic [3:0] ffvec,
                            input bit mb, input bit md, input bit mp, input int me,
                            input bit mf, input logic [3:0] mfv, input logic pdone);
        int le, lf;
        chk($sformatf("busy%0d", kk), busy, mb);
        chk($sformatf("done%0d", kk), done, md);
        chk($sformatf("pass%0d", kk), pass, mp);
        chk($sformatf("err_count%0d", kk), err, me);
        chk($sformatf("ff_vld%0d", kk), ffv, mf);
        chk($sformatf("ff_vec%0d", kk), ffvec, mfv);
        if (rst_seen) begin
            chk($sformatf("rst_zero%0d", kk), {busy, done, pass, err, ffv, ffvec}, 0);
        end
        if (done && !pdone) begin
            le = lit_err(sweep_id, kk);
            lf = lit_ffvec(sweep_id);
            if (le >= 0) begin
                chk($sformatf("lit_err%0d_s%0d", kk, sweep_id), err, le);
                chk($sformatf("lit_pass%0d_s%0d", kk, sweep_id), pass, (le == 0));
                chk($sformatf("lit_ffvld%0d_s%0d", kk, sweep_id), ffv, (le > 0));
            end
            if (lf >= 0) chk($sformatf("lit_ffvec%0d_s%0d", kk, sweep_id), ffvec, lf);
            chk($sformatf("lit_latency%0d_s%0d", kk, sweep_id), cyc - 1 - last_edge, lat + 1);
        end
    endtask

    // Single compare process, sampling on the falling edge
    always @(negedge clk) begin
        if (cyc > 0) begin
            cmp_inst(0, 1, g_cfg[0].busy, g_cfg[0].done, g_cfg[0].pass,
                     8'(g_cfg[0].err_count), g_cfg[0].ffv, g_cfg[0].ffvec,
                     g_cfg[0].m_busy, g_cfg[0].m_done, g_cfg[0].m_pass, g_cfg[0].m_err,
                     g_cfg[0].m_ffv, g_cfg[0].m_ffvec, prev_done0);
            cmp_inst(1, 4, g_cfg[1].busy, g_cfg[1].done, g_cfg[1].pass,
                     8'(g_cfg[1].err_count), g_cfg[1].ffv, g_cfg[1].ffvec,
                     g_cfg[1].m_busy, g_cfg[1].m_done, g_cfg[1].m_pass, g_cfg[1].m_err,
                     g_cfg[1].m_ffv, g_cfg[1].m_ffvec, prev_done1);
            prev_done0 = g_cfg[0].done;
            prev_done1 = g_cfg[1].done;
            if (to_cnt != to_seen) begin
                chk("done_wait", {31'b0, g_cfg[0].done & g_cfg[1].done}, 1);
                to_seen = to_cnt;
            end
        end
    end

    // gap: 0 back-to-back, 1 every 3rd cycle, 2 random; rst_at: vector index
    // after which reset is pulsed (-1 for none)
    task automatic run_sweep(input int id, input int mode, input int gap,
                             input bit rnd, input bit extra, input int rst_at);
        int n;
        @(negedge clk);
        sweep_id   = id;
        fault      = mode;
        stim_valid = 1'b1;             // stray valid while not running
        stim       = 4'($urandom);
        @(negedge clk);
        stim_valid = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < NV; i++) begin
            stim_valid = 1'b1;
            stim       = rnd ? 4'($urandom) : 4'(i);
            start      = extra && (i % 5 == 2);
            if (i == NV - 1) last_edge = cyc;
            @(negedge clk);
            stim_valid = 1'b0;
            start      = 1'b0;
            if (rst_at == i) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            n = (gap == 1) ? 2 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (n) @(negedge clk);
        end
        stim_valid = 1'b1;             // extra valid beyond NUM_VEC
        stim       = 4'($urandom);
        @(negedge clk);
        stim_valid = 1'b0;
        n = 0;
        while (!(g_cfg[0].done && g_cfg[1].done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) to_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stim_valid = 1'b0; stim = 4'h0;
        fault = 0; sweep_id = -1; last_edge = 0; cyc = 0;
        to_cnt = 0; to_seen = 0; n_pass = 0; n_total = 0;
        prev_done0 = 1'b0; prev_done1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, 0, 0, 0, 0, -1);  // golden, 0..15 back-to-back
        run_sweep(1, 1, 0, 0, 0, -1);  // g stuck-at-0
        run_sweep(2, 2, 0, 0, 0, -1);  // f inverted for 4'hB
        run_sweep(3, 0, 1, 0, 0, -1);  // golden, every 3rd cycle
        run_sweep(4, 3, 0, 0, 1, -1);  // all inverted, extra starts in RUN
        run_sweep(5, 0, 0, 0, 0, 7);   // reset after vector 7
        run_sweep(6, 0, 0, 1, 0, -1);  // full clean sweep after reset
        for (int s = 7; s < 12; s++) begin
            run_sweep(s, int'($urandom_range(0, 3)), 2, 1, 1, -1);
        end
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
